// File: rtl/sound_pkg.sv
// Shared constants and types for the keyboard voice scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sound_pkg;

  localparam int HP_W      = 17;
  localparam int KEY_IDX_W = 3;

  // Half-period counts (in CLOCK_50 cycles, minus one) for keys C4..C5.
  localparam logic [HP_W-1:0] KEY_HALF_PERIOD [0:7] = '{
    17'd95555, 17'd85130, 17'd75840, 17'd71586,
    17'd63774, 17'd56817, 17'd50618, 17'd47777
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/keyboard_voice_scheduler_if.sv
// Audio_Controller sample-exchange bundle (ADC pop side + DAC push side).
// Latency: n/a (wires only).
// Backpressure: available/allowed flags gate the read/write strobes.
interface keyboard_voice_scheduler_if;

  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  // Scheduler side: consumes flags and FIFO heads, produces strobes and samples.
  modport master (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  // Audio_Controller side.
  modport slave (
    output audio_in_available,
    output audio_out_allowed,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );

endinterface

// File: rtl/keyboard_voice_scheduler_tone_voice.sv
// One square-wave voice: busy/key registers plus half-period counter and phase.
// Latency: load/release take effect on the next edge; phase toggles every HP+1 cycles.
// Backpressure: none; load has priority over release.
module tone_voice
  import sound_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [KEY_IDX_W-1:0] load_key,
  input  logic                 rel,
  input  logic [HP_W-1:0]      half_period,
  output logic                 busy,
  output logic [KEY_IDX_W-1:0] key,
  output logic                 phase
);

  logic [HP_W-1:0] cnt;

  // Allocation, release and free-running half-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      key   <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      busy  <= 1'b1;
      key   <= load_key;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (rel) begin
      busy  <= 1'b0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (busy) begin
      if (cnt == half_period) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_voice_scheduler.sv
// Key-to-voice allocator, square-wave mixer and Audio_Controller transfer sequencer.
// Latency: press->voice 2 edges; transfer strobes 1 edge after available&allowed, max 1 per 3 cycles.
// Backpressure: waits in IDLE until available&allowed; a started transfer always completes.
// Optional build macro VOICE_STEAL_EN: steal a voice round-robin instead of dropping a press.
module keyboard_voice_scheduler
  import sound_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int AMP        = 25000000
) (
  input  logic                            CLOCK_50,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic [NUM_KEYS-1:0]             key_down,
  keyboard_voice_scheduler_if.master      audio,
  output logic [NUM_VOICES-1:0]           voice_busy,
  output logic [NUM_VOICES*KEY_IDX_W-1:0] voice_key,
  output logic                            dropped
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [31:0] AMP_S = 32'(AMP);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_XFER = XFER;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [NUM_KEYS-1:0]   key_prev;
  logic [NUM_KEYS-1:0]   pend;
  logic [NUM_KEYS-1:0]   rise;
  logic [NUM_KEYS-1:0]   fall;
  logic [NUM_KEYS-1:0]   cand;
  logic [NUM_KEYS-1:0]   svc_clr;
  logic                  svc_vld;
  logic [KEY_IDX_W-1:0]  svc_key;
  logic                  free_vld;
  logic [VIDX_W-1:0]     free_idx;
  logic [NUM_VOICES-1:0] load_vec;
  logic [NUM_VOICES-1:0] rel_vec;
  logic [NUM_VOICES-1:0] voice_phase;
  logic [KEY_IDX_W-1:0]  vkey [NUM_VOICES];
  logic [HP_W-1:0]       vhp  [NUM_VOICES];
  logic                  drop_now;
  logic signed [31:0]    mix;
  logic [1:0]            state;

`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0]     steal_ptr;
`endif

  assign rise = key_down & ~key_prev;
  assign fall = ~key_down & key_prev;
  // A key released in the same cycle it would be serviced is simply forgotten.
  assign cand = pend & ~fall;

  // Pick the lowest-index pending key.
  always_comb begin
    svc_vld = 1'b0;
    svc_key = '0;
    svc_clr = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (cand[i] && !svc_vld) begin
        svc_vld    = 1'b1;
        svc_key    = KEY_IDX_W'(i);
        svc_clr[i] = 1'b1;
      end
    end
  end

  // Pick the lowest-index free voice.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_busy[v] && !free_vld) begin
        free_vld = 1'b1;
        free_idx = VIDX_W'(v);
      end
    end
  end

  // Route the serviced key to a free voice, or steal/drop when none is free.
  always_comb begin
    load_vec = '0;
    drop_now = 1'b0;
    if (svc_vld) begin
      if (free_vld) begin
        load_vec[free_idx] = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        load_vec[steal_ptr] = 1'b1;
`else
        drop_now = 1'b1;
`endif
      end
    end
  end

  // A voice releases when the key it holds goes up.
  always_comb begin
    rel_vec = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      rel_vec[v] = voice_busy[v] & fall[vkey[v]];
    end
  end

  // Key edge history, pending presses and the drop pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_prev <= '0;
      pend     <= '0;
      dropped  <= 1'b0;
    end else begin
      key_prev <= key_down;
      pend     <= (pend | rise) & ~fall & ~svc_clr;
      dropped  <= drop_now;
    end
  end

`ifdef VOICE_STEAL_EN
  // Round-robin victim pointer, advanced after every steal.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      steal_ptr <= '0;
    end else if (svc_vld && !free_vld) begin
      if (steal_ptr == VIDX_W'(NUM_VOICES - 1)) begin
        steal_ptr <= '0;
      end else begin
        steal_ptr <= steal_ptr + 1'b1;
      end
    end
  end
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_VOICES; g++) begin : g_voice
      assign vhp[g] = KEY_HALF_PERIOD[vkey[g]];
      assign voice_key[g*KEY_IDX_W +: KEY_IDX_W] = vkey[g];

      tone_voice u_voice (
        .clk         (CLOCK_50),
        .rst_n       (resetn),
        .load        (load_vec[g]),
        .load_key    (svc_key),
        .rel         (rel_vec[g]),
        .half_period (vhp[g]),
        .busy        (voice_busy[g]),
        .key         (vkey[g]),
        .phase       (voice_phase[g])
      );
    end
  endgenerate

  // Signed sum of busy voices; gated to zero when disabled.
  always_comb begin
    mix = '0;
    if (enable) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_busy[v]) begin
          mix = mix + (voice_phase[v] ? AMP_S : -AMP_S);
        end
      end
    end
  end

  // Three-state transfer sequencer: capture in IDLE, strobe in XFER, settle in HOLD.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                         <= ST_IDLE;
      audio.read_audio_in           <= 1'b0;
      audio.write_audio_out         <= 1'b0;
      audio.left_channel_audio_out  <= '0;
      audio.right_channel_audio_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (audio.audio_in_available && audio.audio_out_allowed) begin
            audio.left_channel_audio_out  <= audio.left_channel_audio_in + $unsigned(mix);
            audio.right_channel_audio_out <= audio.right_channel_audio_in + $unsigned(mix);
            audio.read_audio_in           <= 1'b1;
            audio.write_audio_out         <= 1'b1;
            state                         <= ST_XFER;
          end
        end
        ST_XFER: begin
          audio.read_audio_in   <= 1'b0;
          audio.write_audio_out <= 1'b0;
          state                 <= ST_HOLD;
        end
        ST_HOLD: begin
          state <= ST_IDLE;
        end
        default: begin
          audio.read_audio_in   <= 1'b0;
          audio.write_audio_out <= 1'b0;
          state                 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_voice_scheduler.sv
// Directed bench for keyboard_voice_scheduler: reset, transfer cadence, allocation,
// drop/steal, release/reallocation, tone phase, mix wrap and reset during a transfer.
// Expected values are hand-computed constants.
module tb_keyboard_voice_scheduler;

  localparam int AMP = 25000000;

  logic        CLOCK_50;
  logic        resetn;
  logic        enable;
  logic [7:0]  key_down;
  logic [3:0]  voice_busy;
  logic [11:0] voice_key;
  logic        dropped;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  keyboard_voice_scheduler_if audio ();

  keyboard_voice_scheduler #(
    .NUM_KEYS   (8),
    .NUM_VOICES (4),
    .AMP        (AMP)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .enable     (enable),
    .key_down   (key_down),
    .audio      (audio),
    .voice_busy (voice_busy),
    .voice_key  (voice_key),
    .dropped    (dropped)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  // Run one complete transfer from IDLE and park the FSM back in IDLE.
  task automatic do_xfer(input logic [31:0] l, input logic [31:0] r);
    audio.left_channel_audio_in  = l;
    audio.right_channel_audio_in = r;
    audio.audio_in_available     = 1'b1;
    audio.audio_out_allowed      = 1'b1;
    tick();
    audio.audio_in_available     = 1'b0;
    audio.audio_out_allowed      = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic exp_stb;
    resetn = 1'b0;
    #5;
    checks++;
    if ({audio.read_audio_in, audio.write_audio_out, dropped} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b required 000", {audio.read_audio_in, audio.write_audio_out, dropped});
    end
    checks++;
    if ({audio.left_channel_audio_out, audio.right_channel_audio_out} !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h required 0", {audio.left_channel_audio_out, audio.right_channel_audio_out});
    end
    checks++;
    if ({voice_busy, voice_key} !== 16'h0) begin
      errors++; $display("FAIL reset_voices got %h required 0", {voice_busy, voice_key});
    end
    tick();
    checks++;
    if (audio.write_audio_out !== 1'b0) begin
      errors++; $display("FAIL reset_hold_write got %b required 0", audio.write_audio_out);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if ({audio.read_audio_in, audio.write_audio_out} !== 2'b11) begin
      errors++; $display("FAIL first_xfer_strobes got %b required 11", {audio.read_audio_in, audio.write_audio_out});
    end
    checks++;
    if (audio.left_channel_audio_out !== 32'd5 || audio.right_channel_audio_out !== 32'd9) begin
      errors++; $display("FAIL first_xfer_data got %h/%h required 5/9", audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_stb = ((k % 3) == 0);
      checks++;
      if (audio.read_audio_in !== exp_stb || audio.write_audio_out !== exp_stb) begin
        errors++; $display("FAIL cadence_k%0d got %b%b required %b%b", k, audio.read_audio_in, audio.write_audio_out, exp_stb, exp_stb);
      end
    end
    audio.audio_in_available = 1'b0;
    audio.audio_out_allowed  = 1'b0;
    checks++;
    if (audio.left_channel_audio_out !== 32'd5) begin
      errors++; $display("FAIL cadence_data got %h required 5", audio.left_channel_audio_out);
    end
  endtask

  task automatic test_single_voice();
    int l_cyc;
    key_down = 8'h20;
    tick();
    checks++;
    if (voice_busy !== 4'b0000) begin
      errors++; $display("FAIL single_pend got %b required 0000", voice_busy);
    end
    tick();
    l_cyc = cyc;
    checks++;
    if (voice_busy !== 4'b0001 || voice_key[2:0] !== 3'd5 || dropped !== 1'b0) begin
      errors++; $display("FAIL single_alloc got %b/%0d/%b required 0001/5/0", voice_busy, voice_key[2:0], dropped);
    end
    do_xfer(32'h8000_0000, 32'h0);
    checks++;
    if (audio.left_channel_audio_out !== 32'h7E82_87C0 || audio.right_channel_audio_out !== 32'hFE82_87C0) begin
      errors++; $display("FAIL phase0_mix got %h/%h required 7e8287c0/fe8287c0", audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
    while (cyc < l_cyc + 56817) tick();
    do_xfer(32'h0, 32'h0);
    checks++;
    if (audio.left_channel_audio_out !== 32'hFE82_87C0) begin
      errors++; $display("FAIL phase_before_toggle got %h required fe8287c0", audio.left_channel_audio_out);
    end
    do_xfer(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (audio.left_channel_audio_out !== 32'h817D_783F || audio.right_channel_audio_out !== 32'h017D_783F) begin
      errors++; $display("FAIL phase1_wrap got %h/%h required 817d783f/017d783f", audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
    enable = 1'b0;
    do_xfer(32'd123, 32'd456);
    enable = 1'b1;
    checks++;
    if (audio.left_channel_audio_out !== 32'd123 || audio.right_channel_audio_out !== 32'd456) begin
      errors++; $display("FAIL enable_gate got %0d/%0d required 123/456", audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
    key_down = 8'h00;
    tick();
    checks++;
    if (voice_busy !== 4'b0000) begin
      errors++; $display("FAIL single_release got %b required 0000", voice_busy);
    end
    do_xfer(32'd11, 32'd22);
    checks++;
    if (audio.left_channel_audio_out !== 32'd11 || audio.right_channel_audio_out !== 32'd22) begin
      errors++; $display("FAIL free_voice_mix got %0d/%0d required 11/22", audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
  endtask

  task automatic test_multi_alloc();
    logic [3:0] exp_busy;
    key_down = 8'h1F;
    tick();
    checks++;
    if (voice_busy !== 4'b0000) begin
      errors++; $display("FAIL multi_pend got %b required 0000", voice_busy);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_busy = 4'((1 << k) - 1);
      checks++;
      if (voice_busy !== exp_busy || dropped !== 1'b0) begin
        errors++; $display("FAIL multi_alloc_k%0d got %b/%b required %b/0", k, voice_busy, dropped, exp_busy);
      end
    end
    checks++;
    if (voice_key !== 12'h688) begin
      errors++; $display("FAIL multi_keys got %h required 688", voice_key);
    end
    tick();
`ifdef VOICE_STEAL_EN
    checks++;
    if (dropped !== 1'b0 || voice_key !== 12'h68C || voice_busy !== 4'hF) begin
      errors++; $display("FAIL steal got %b/%h/%b required 0/68c/1111", dropped, voice_key, voice_busy);
    end
`else
    checks++;
    if (dropped !== 1'b1 || voice_key !== 12'h688 || voice_busy !== 4'hF) begin
      errors++; $display("FAIL drop got %b/%h/%b required 1/688/1111", dropped, voice_key, voice_busy);
    end
`endif
    tick();
    checks++;
    if (dropped !== 1'b0) begin
      errors++; $display("FAIL drop_one_cycle got %b required 0", dropped);
    end
  endtask

  task automatic test_release_realloc();
    logic [11:0] exp_key;
    key_down = 8'h1D;
    tick();
    checks++;
    if (voice_busy !== 4'b1101) begin
      errors++; $display("FAIL release_v1 got %b required 1101", voice_busy);
    end
    key_down = 8'h9D;
    tick();
    checks++;
    if (voice_busy !== 4'b1101) begin
      errors++; $display("FAIL realloc_pend got %b required 1101", voice_busy);
    end
    tick();
`ifdef VOICE_STEAL_EN
    exp_key = 12'h6BC;
`else
    exp_key = 12'h6B8;
`endif
    checks++;
    if (voice_busy !== 4'b1111 || voice_key !== exp_key || dropped !== 1'b0) begin
      errors++; $display("FAIL realloc_v1 got %b/%h/%b required 1111/%h/0", voice_busy, voice_key, dropped, exp_key);
    end
    key_down = 8'h00;
    tick();
    checks++;
    if (voice_busy !== 4'b0000) begin
      errors++; $display("FAIL release_all got %b required 0000", voice_busy);
    end
  endtask

  task automatic test_reset_mid_xfer();
    key_down = 8'h01;
    tick();
    tick();
    audio.left_channel_audio_in  = 32'd5;
    audio.right_channel_audio_in = 32'd5;
    audio.audio_in_available     = 1'b1;
    audio.audio_out_allowed      = 1'b1;
    tick();
    checks++;
    if (audio.write_audio_out !== 1'b1 || audio.left_channel_audio_out !== 32'hFE82_87C5) begin
      errors++; $display("FAIL pre_abort got %b/%h required 1/fe8287c5", audio.write_audio_out, audio.left_channel_audio_out);
    end
    #2;
    resetn                   = 1'b0;
    audio.audio_in_available = 1'b0;
    audio.audio_out_allowed  = 1'b0;
    key_down                 = 8'h00;
    #1;
    checks++;
    if ({audio.read_audio_in, audio.write_audio_out, dropped} !== 3'b000 ||
        {audio.left_channel_audio_out, audio.right_channel_audio_out} !== 64'h0) begin
      errors++; $display("FAIL abort_outputs got %b%b%b/%h/%h required 000/0/0", audio.read_audio_in,
                         audio.write_audio_out, dropped, audio.left_channel_audio_out, audio.right_channel_audio_out);
    end
    checks++;
    if ({voice_busy, voice_key} !== 16'h0) begin
      errors++; $display("FAIL abort_voices got %h required 0", {voice_busy, voice_key});
    end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (audio.write_audio_out !== 1'b0 || audio.read_audio_in !== 1'b0 || audio.left_channel_audio_out !== 32'h0) begin
        errors++; $display("FAIL post_abort_k%0d got %b%b/%h required 00/0", k, audio.read_audio_in,
                           audio.write_audio_out, audio.left_channel_audio_out);
      end
    end
  endtask

  initial begin
    resetn                       = 1'b0;
    enable                       = 1'b1;
    key_down                     = 8'h00;
    audio.audio_in_available     = 1'b1;
    audio.audio_out_allowed      = 1'b1;
    audio.left_channel_audio_in  = 32'd5;
    audio.right_channel_audio_in = 32'd9;
    test_reset();
    test_single_voice();
    test_multi_alloc();
    test_release_realloc();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_voice_scheduler.md
Name: keyboard_voice_scheduler

Overview:
- Allocates keyboard key presses to a fixed pool of square-wave tone voices and mixes the active voices into one signed sample.
- Sequences sample transfers to the Audio_Controller. Each transfer pairs one audio-in read with one audio-out write, and the output is the input sample plus the voice mix.
- Sits between the debounced key/switch inputs and Audio_Controller. It replaces the ad-hoc single-tone logic in the top level.

Parameters:
- NUM_KEYS, 8: number of key inputs. Indices map to C4..C5 in sound_pkg.
- NUM_VOICES, 4: number of simultaneous voices.
- AMP, 25000000: per-voice amplitude. NUM_VOICES*AMP must stay below 2^31.

Ports:
- CLOCK_50 in 1: system clock, 50 MHz.
- resetn in 1: asynchronous, active-low reset.
- enable in 1: voice mix gate. When 0, the mix is forced to 0 and voices keep running.
- key_down in NUM_KEYS: level per key, synchronous to CLOCK_50, 1 = pressed.
- audio_in_available in 1: from Audio_Controller.
- audio_out_allowed in 1: from Audio_Controller.
- left_channel_audio_in in 32: show-ahead head of the ADC FIFO, left channel.
- right_channel_audio_in in 32: show-ahead head of the ADC FIFO, right channel.
- read_audio_in out 1: one-cycle pop of the ADC FIFO.
- write_audio_out out 1: one-cycle push to the DAC FIFO.
- left_channel_audio_out out 32: sample to the DAC, left channel.
- right_channel_audio_out out 32: sample to the DAC, right channel.
- voice_busy out NUM_VOICES: allocation status per voice.
- voice_key out NUM_VOICES*3: key index held by each voice.
- dropped out 1: one-cycle pulse when a press cannot be allocated.

Behaviour:
- Reset (resetn=0, asynchronous): all outputs 0; voices free; counters and phases 0; pend=0; key_prev=0; FSM to IDLE. Asserting reset mid-transfer aborts the transfer; no write pulse follows.
- Edge detect: key_prev registers key_down. rise = key_down & ~key_prev; fall = ~key_down & key_prev.
- pend holds keys with an unserviced rise. A fall clears that key's pend bit with no dropped pulse.
- Release: on a fall, the voice holding that key clears voice_busy on the next edge. The freed voice is usable from the following cycle.
- Allocation: at most one per cycle. Service the lowest-index pending key; assign it the lowest-index free voice.
- On allocation, next edge: voice_busy=1, voice_key=key index, counter=0, phase=0, and the pend bit clears.
- No free voice: clear the pend bit and pulse dropped for 1 cycle (without VOICE_STEAL_EN).
- Voice tone: the counter increments each cycle while busy. When it equals HALF_PERIOD[voice_key], the counter goes to 0 and phase toggles. Tone period = 2*(HP+1) cycles.
- Mix, combinational: sum over busy voices of (phase ? +AMP : -AMP). A free voice contributes 0. 32-bit two's complement. Result is 0 when enable=0.
- Output add: out = in + mix per channel, modulo 2^32 (wraps, no saturation).
- Transfer FSM, states IDLE, XFER, HOLD:
  - IDLE: if audio_in_available & audio_out_allowed, register both outputs from the current FIFO head plus the current mix, then go to XFER.
  - XFER: read_audio_in = write_audio_out = 1 for exactly this cycle; next state HOLD.
  - HOLD: strobes 0, one cycle for controller flags to update; then IDLE.
- Strobes are registered outputs and are 0 in IDLE and HOLD. Maximum rate is one transfer per 3 cycles.
- Output data holds its value between transfers.
- If available or allowed drop during XFER, the transfer still completes; the controller guarantees one free slot.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: with no free voice, steal the voice at steal_ptr. steal_ptr is a round-robin pointer, reset 0, incremented modulo NUM_VOICES after each steal. The stolen voice reloads key, counter=0, phase=0. dropped never pulses.
- Undefined: drop behaviour as above; steal_ptr is not built.

Decomposition:
- sound_pkg: KEY_HALF_PERIOD[0:7] = 95555, 85130, 75840, 71586, 63774, 56817, 50618, 47777 (17-bit constants); HP_W=17; KEY_IDX_W=3; transfer state enum {IDLE, XFER, HOLD}.
- Sub-module tone_voice, instantiated NUM_VOICES times. It contains the counter, phase, busy and key registers, with load, release and half_period inputs and phase/busy outputs.
- Allocation, mix and transfer FSM stay in the top module.

Test Plan:
- Reset with key_down=0, avail=allowed=1, sine-free input 5 → outputs after first transfer equal 5; strobes pulse every 3rd cycle exactly.
- Press key 5 (A4) → voice0 busy, voice_key[2:0]=5 next cycle; phase toggles every 56818 cycles; in=0 gives outputs alternating −25000000/+25000000.
- Press keys 0,1,2,3,4 in the same cycle → voices 0-3 get keys 0-3 over 4 consecutive cycles; key 4 produces dropped=1. With VOICE_STEAL_EN, voice0 gets key 4 instead and steal_ptr=1.
- Release key 1 while 4 voices busy, then press key 7 → voice1 freed, then reallocated to key 7.
- Input 0x7FFFFFFF with one voice at phase 1 → output wraps to 0x7FFFFFFF+25000000 mod 2^32; deassert resetn during XFER → no write pulse, all outputs 0.
